// File: rtl/datapath_pkg.sv
`default_nettype none
// ============================================================================
// Module   : datapath_pkg
// Brief    : Shared types for the dispatch stage: FU ids, register indices,
//            result-status entries and buffered instruction entries.
// Revision : 1.0 - initial release
// ============================================================================
package datapath_pkg;

    localparam int C_NREGS   = 32;
    localparam int C_NFU     = 3;
    localparam int C_INSTR_W = 32;
    localparam int C_REG_W   = $clog2(C_NREGS);
    localparam int C_FU_W    = $clog2(C_NFU);

    typedef logic [C_FU_W-1:0]  fu_id_t;
    typedef logic [C_REG_W-1:0] reg_idx_t;

    typedef struct packed {
        logic   valid;
        fu_id_t fu;
    } stat_entry_t;

    typedef struct packed {
        logic [C_INSTR_W-1:0] instr;
        fu_id_t               fu;
        reg_idx_t             rd;
        reg_idx_t             rs1;
        reg_idx_t             rs2;
        logic                 wen;
    } disp_entry_t;

    // True when the entry is live and owned by the given FU.
    function automatic logic stat_owned_by(input stat_entry_t e, input fu_id_t fu);
        return e.valid && (e.fu == fu);
    endfunction

endpackage
`default_nettype wire

// File: rtl/rstat_table.sv
`default_nettype none
// ============================================================================
// Module   : rstat_table
// Brief    : Register result-status table (which FU will write each reg).
//            Set port wins over clear port; DISPATCH_WB_BYPASS_EN forwards a
//            same-cycle matching clear onto the read ports.
// Revision : 1.0 - initial release
// ============================================================================
module rstat_table
    import datapath_pkg::*;
#(
    parameter int NREGS = C_NREGS
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_set_en,
    input  reg_idx_t    i_set_rd,
    input  fu_id_t      i_set_fu,
    input  logic        i_clr_valid,
    input  reg_idx_t    i_clr_rd,
    input  fu_id_t      i_clr_fu,
    input  reg_idx_t    i_rs1,
    input  reg_idx_t    i_rs2,
    input  reg_idx_t    i_rd,
    output stat_entry_t o_rs1,
    output stat_entry_t o_rs2,
    output logic        o_rd_busy
);

    stat_entry_t r_stat [NREGS];
    logic        w_clr;

    // Writebacks from a FU that no longer owns the register are stale.
    assign w_clr = i_clr_valid && stat_owned_by(r_stat[i_clr_rd], i_clr_fu);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) r_stat[i] <= '0;
        end else begin
            if (w_clr) r_stat[i_clr_rd] <= '0;
            if (i_set_en && (i_set_rd != '0)) r_stat[i_set_rd] <= '{valid: 1'b1, fu: i_set_fu};
        end
    end

`ifdef DISPATCH_WB_BYPASS_EN
    always_comb begin
        o_rs1     = r_stat[i_rs1];
        o_rs2     = r_stat[i_rs2];
        o_rd_busy = r_stat[i_rd].valid;
        if (w_clr && (i_clr_rd == i_rs1)) o_rs1 = '0;
        if (w_clr && (i_clr_rd == i_rs2)) o_rs2 = '0;
        if (w_clr && (i_clr_rd == i_rd))  o_rd_busy = 1'b0;
    end
`else
    assign o_rs1     = r_stat[i_rs1];
    assign o_rs2     = r_stat[i_rs2];
    assign o_rd_busy = r_stat[i_rd].valid;
`endif

endmodule
`default_nettype wire

// File: rtl/dispatch_sched.sv
`default_nettype none
// ============================================================================
// Module   : dispatch_sched
// Brief    : Dispatch stage: DEPTH-entry instruction FIFO gated by WAW and
//            FU-busy hazards. Option: DISPATCH_WB_BYPASS_EN (wb bypass).
// Revision : 1.0 - initial release
// ============================================================================
module dispatch_sched
    import datapath_pkg::*;
#(
    parameter  int NREGS   = C_NREGS,
    parameter  int NFU     = C_NFU,
    parameter  int DEPTH   = 4,
    parameter  int INSTR_W = C_INSTR_W,
    localparam int REG_W   = $clog2(NREGS),
    localparam int FU_W    = $clog2(NFU),
    localparam int CNT_W   = $clog2(DEPTH) + 1
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               flush,
    input  logic               freeze,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [INSTR_W-1:0] in_instr,
    input  logic [FU_W-1:0]    in_fu,
    input  logic [REG_W-1:0]   in_rd,
    input  logic [REG_W-1:0]   in_rs1,
    input  logic [REG_W-1:0]   in_rs2,
    input  logic               in_wen,
    input  logic [NFU-1:0]     fu_busy,
    input  logic               wb_valid,
    input  logic [REG_W-1:0]   wb_rd,
    input  logic [FU_W-1:0]    wb_fu,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [INSTR_W-1:0] out_instr,
    output logic [FU_W-1:0]    out_fu,
    output logic [REG_W-1:0]   out_rd,
    output logic [REG_W-1:0]   out_rs1,
    output logic [REG_W-1:0]   out_rs2,
    output logic               out_wen,
    output logic               out_rs1_pend,
    output logic               out_rs2_pend,
    output logic [FU_W-1:0]    out_rs1_fu,
    output logic [FU_W-1:0]    out_rs2_fu,
    output logic [CNT_W-1:0]   count
);

    localparam int PTR_W  = $clog2(DEPTH);
    localparam int BUSY_W = 1 << FU_W;

    disp_entry_t        r_mem [DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [CNT_W-1:0]   r_count;

    disp_entry_t        w_head;
    disp_entry_t        w_in;
    stat_entry_t        w_rs1_stat;
    stat_entry_t        w_rs2_stat;
    logic               w_rd_busy;
    logic               w_waw;
    logic               w_hazard;
    logic               w_enq;
    logic               w_deq;
    logic               w_set_en;
    logic [BUSY_W-1:0]  w_busy_ext;

    assign w_head = r_mem[r_rd_ptr];
    assign w_in   = '{instr: in_instr, fu: in_fu, rd: in_rd, rs1: in_rs1, rs2: in_rs2, wen: in_wen};

    // Deliberately independent of dequeue: a full buffer never accepts.
    assign in_ready = (r_count < CNT_W'(DEPTH)) && !freeze && !flush;
    assign w_enq    = in_valid && in_ready;

    // Pad so an out-of-range FU id reads as not busy.
    assign w_busy_ext = BUSY_W'(fu_busy);
    assign w_waw      = w_head.wen && (w_head.rd != '0) && w_rd_busy;
    assign w_hazard   = w_waw || w_busy_ext[w_head.fu];
    assign out_valid  = (r_count != '0) && !w_hazard && !freeze && !flush;
    assign w_deq      = out_valid && out_ready;
    assign w_set_en   = w_deq && w_head.wen && (w_head.rd != '0);

    assign out_instr    = w_head.instr;
    assign out_fu       = w_head.fu;
    assign out_rd       = w_head.rd;
    assign out_rs1      = w_head.rs1;
    assign out_rs2      = w_head.rs2;
    assign out_wen      = w_head.wen;
    assign out_rs1_pend = (w_head.rs1 != '0) && w_rs1_stat.valid;
    assign out_rs2_pend = (w_head.rs2 != '0) && w_rs2_stat.valid;
    assign out_rs1_fu   = w_rs1_stat.fu;
    assign out_rs2_fu   = w_rs2_stat.fu;
    assign count        = r_count;

    // freeze and flush already block w_enq/w_deq, so only flush needs a branch.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_enq) begin
                r_mem[r_wr_ptr] <= w_in;
                r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
            end
            if (w_deq) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            r_count <= r_count + CNT_W'(w_enq) - CNT_W'(w_deq);
        end
    end

    rstat_table #(
        .NREGS (NREGS)
    ) u_rstat (
        .clk         (CLK),
        .rst         (RST),
        .i_set_en    (w_set_en),
        .i_set_rd    (w_head.rd),
        .i_set_fu    (w_head.fu),
        .i_clr_valid (wb_valid),
        .i_clr_rd    (wb_rd),
        .i_clr_fu    (wb_fu),
        .i_rs1       (w_head.rs1),
        .i_rs2       (w_head.rs2),
        .i_rd        (w_head.rd),
        .o_rs1       (w_rs1_stat),
        .o_rs2       (w_rs2_stat),
        .o_rd_busy   (w_rd_busy)
    );

endmodule
`default_nettype wire

// File: doc/dispatch_sched.md
Name: dispatch_sched

Overview:
- Parametrised next-generation dispatch stage for the tensor core.
- Buffers decoded instructions from fetch in a DEPTH-entry FIFO and tracks a register result-status table: which FU will write each destination register.
- Releases the FIFO head to issue only when there is no WAW hazard and the target FU is free.
- Scalar/matrix/GEMM FU classes are generalised to NFU units; writeback clears result status.

Parameters:
- NREGS, 32, architectural register count; REG_W = $clog2(NREGS).
- NFU, 3, number of functional units; FU_W = $clog2(NFU).
- DEPTH, 4, instruction buffer entries; power of two, >= 2.
- INSTR_W, 32, raw instruction width.

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  asynchronous, active-high reset.
- flush  in  1  discard all buffered instructions.
- freeze  in  1  hold stage; no enqueue or dequeue.
- in_valid  in  1  fetch presents an instruction.
- in_ready  out  1  buffer can accept.
- in_instr  in  INSTR_W  raw instruction.
- in_fu  in  FU_W  target FU.
- in_rd, in_rs1, in_rs2  in  REG_W each  register indices.
- in_wen  in  1  instruction writes rd.
- fu_busy  in  NFU  per-FU busy from issue.
- wb_valid  in  1  writeback event.
- wb_rd  in  REG_W  register written back.
- wb_fu  in  FU_W  FU performing the writeback.
- out_valid  out  1  head instruction is dispatchable.
- out_ready  in  1  issue accepts.
- out_instr, out_fu, out_rd, out_rs1, out_rs2, out_wen  out  fields of the head entry.
- out_rs1_pend, out_rs2_pend  out  1 each  source still owned by an in-flight FU.
- out_rs1_fu, out_rs2_fu  out  FU_W each  producing FU (valid when pend=1).
- count  out  $clog2(DEPTH)+1  occupancy.

Behaviour:
- Reset: FIFO empty, all status entries cleared.
  - Outputs at reset: count=0, in_ready=1, out_valid=0, pend=0; all other outputs 0.
- Enqueue when in_valid & in_ready.
  - in_ready = (count<DEPTH) & !freeze & !flush.
  - in_ready does not depend on same-cycle dequeue, so a full FIFO rejects input even while the head leaves.
- Latency: an enqueued instruction is at the head at earliest on the next cycle. There is no empty-buffer bypass.
- Head fields are driven combinationally from the FIFO read pointer.
- hazard = out_wen & rd!=0 & stat_valid[rd] (WAW), or fu_busy[out_fu].
- out_valid = count!=0 & !hazard & !freeze & !flush.
- Dequeue on out_valid & out_ready. On dequeue with out_wen and rd!=0: stat[rd] <= {valid=1, fu=out_fu}.
- Writeback: if wb_valid & stat_valid[wb_rd] & stat_fu[wb_rd]==wb_fu, clear stat[wb_rd].
  - A writeback from a non-matching FU is ignored (stale producer).
- Same cycle dequeue-set and writeback-clear on the same register: the set wins.
- Register 0 is never tracked. Its pend flags are always 0.
- Operand pend/fu outputs reflect table state at the start of the cycle.
- Flush: FIFO pointers and count go to 0 on the next edge; any enqueue that cycle is dropped.
  - The status table is retained, since in-flight FUs still write back.
  - Writeback is still processed during flush.
- Freeze: FIFO pointers held. Writeback is still processed.
- Flush takes precedence over freeze.
- Pointers wrap modulo DEPTH. count distinguishes full from empty.
- RST asserted mid-operation clears everything asynchronously; outputs return to reset values immediately.

Optional Feature:
- Macro DISPATCH_WB_BYPASS_EN.
- Defined: a same-cycle matching writeback on the head's rd removes the WAW hazard, so the head may dispatch that cycle.
  - The same bypass clears out_rsX_pend when wb_rd equals that source.
  - The status entry then takes the new set (set wins).
- Undefined: hazard and pend use registered table state only; the head dispatches one cycle after the writeback.

Decomposition:
- datapath_pkg gains: fu_id_t (FU_W), reg_idx_t (REG_W), stat_entry_t {valid, fu}, disp_entry_t {instr, fu, rd, rs1, rs2, wen}.
- Sub-module rstat_table holds the result-status table:
  - set port and clear port, set-wins rule;
  - two read ports, plus one read port for rd.
- The FIFO stays inline in dispatch_sched.

Test Plan:
- Reset then enqueue add rd=5 fu=0 with fu_busy=0 -> out_valid=1 next cycle. Accept -> stat[5]={1,0}, count=0.
- Dispatch rd=5 fu=1, then enqueue rd=5 fu=0 -> out_valid=0 until wb_valid rd=5 fu=1; dispatches the cycle after (same cycle with DISPATCH_WB_BYPASS_EN).
- wb rd=5 fu=2 while stat[5]={1,1} -> entry unchanged, hazard persists.
- Fill 4 entries with out_ready=0 -> in_ready=0, count=4. Pulse out_ready while in_valid=1 -> exactly one dequeue, no enqueue that cycle.
- With 3 entries queued, assert flush while in_valid=1 -> count=0 next cycle, out_valid=0, stat entries unchanged.
- Set fu_busy[2]=1 with head fu=2 and freeze toggling -> no dequeue while busy or frozen. Dequeue on the first cycle both are low with out_ready=1.
